// File: rtl/dbus_tx_pkg.sv
// Shared D-bus definitions: state encodings, default timeout and line levels.
// Used by dbus_tx and the future dbus_rx.
package dbus_tx_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDropWait = 3'd1,
    StAssert   = 3'd2,
    StWaitAck  = 3'd3,
    StWaitRel  = 3'd4,
    StDone     = 3'd5,
    StRecover  = 3'd6,
    StGap      = 3'd7
  } dbus_state_e;

  // 100 ms at 24 MHz
  localparam int unsigned DbusTimeoutDefault = 2400000;

  // Open-drain lines float high when nobody pulls them
  localparam logic LineIdle = 1'b1;

endpackage

// File: rtl/dbus_sync.sv
// Two-flop synchroniser for an asynchronous D-bus line; resets to the idle level.
module dbus_sync
  import dbus_tx_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta   <= LineIdle;
      o_sync <= LineIdle;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/dbus_tx.sv
// D-bus byte transmitter: pulls bytes from the UART RX FIFO and sends them LSB first on tip/ring.
// Define DBUS_TX_GAP_EN to enforce a minimum idle gap of c_GAP cycles between bytes.
module dbus_tx
  import dbus_tx_pkg::*;
#(
  parameter int unsigned c_TIMEOUT      = DbusTimeoutDefault,
  parameter int unsigned c_TIMEOUTWIDTH = 22
`ifdef DBUS_TX_GAP_EN
  ,
  parameter int unsigned c_GAP          = 240
`endif
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_avail,
  output logic       o_read,
  input  logic       i_tip,
  input  logic       i_ring,
  output logic       o_tip_low,
  output logic       o_ring_low,
  output logic       o_busy,
  output logic       o_error
);

  localparam logic [c_TIMEOUTWIDTH-1:0] TimeoutLast = c_TIMEOUTWIDTH'(c_TIMEOUT - 1);

`ifdef DBUS_TX_GAP_EN
  localparam int unsigned GapWidth = (c_GAP > 1) ? $clog2(c_GAP) : 1;
  localparam logic [GapWidth-1:0] GapLast = GapWidth'(c_GAP - 1);
  logic [GapWidth-1:0] gap_cnt;
`endif

  logic                      s_tip;
  logic                      s_ring;
  dbus_state_e               state;
  logic [7:0]                shreg;
  logic [2:0]                bit_cnt;
  logic [c_TIMEOUTWIDTH-1:0] timer;
  logic                      rec_high;
  logic                      wait_state;
  logic                      advance;
  logic                      timeout_hit;

  dbus_sync u_sync_tip (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_tip),
    .o_sync  (s_tip)
  );

  dbus_sync u_sync_ring (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_ring),
    .o_sync  (s_ring)
  );

  // Exit condition of each wait state; a wait that does not advance is what times out
  always_comb begin
    wait_state = 1'b0;
    advance    = 1'b0;
    case (state)
      StDropWait: begin
        wait_state = 1'b1;
        advance    = !i_avail;
      end
      StWaitAck: begin
        wait_state = 1'b1;
        advance    = shreg[0] ? (s_tip != LineIdle) : (s_ring != LineIdle);
      end
      StWaitRel: begin
        wait_state = 1'b1;
        advance    = (s_tip == LineIdle) && (s_ring == LineIdle);
      end
      default: begin
        wait_state = 1'b0;
        advance    = 1'b0;
      end
    endcase
    timeout_hit = (timer == TimeoutLast);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= StIdle;
      shreg      <= '0;
      bit_cnt    <= '0;
      timer      <= '0;
      rec_high   <= 1'b0;
      o_read     <= 1'b0;
      o_tip_low  <= 1'b0;
      o_ring_low <= 1'b0;
      o_busy     <= 1'b0;
      o_error    <= 1'b0;
`ifdef DBUS_TX_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      o_read  <= 1'b0;
      o_error <= 1'b0;
      if (wait_state && !advance && timeout_hit) begin
        // Abort: the byte is dropped, not retransmitted
        o_tip_low  <= 1'b0;
        o_ring_low <= 1'b0;
        o_error    <= 1'b1;
        timer      <= '0;
        rec_high   <= 1'b0;
        state      <= StRecover;
      end else begin
        case (state)
          StIdle: begin
            timer <= '0;
            if (i_avail && (s_tip == LineIdle) && (s_ring == LineIdle)) begin
              shreg   <= i_data;
              o_read  <= 1'b1;
              bit_cnt <= '0;
              o_busy  <= 1'b1;
              state   <= StDropWait;
            end
          end
          StDropWait: begin
            if (advance) begin
              timer <= '0;
              state <= StAssert;
            end else begin
              timer <= timer + c_TIMEOUTWIDTH'(1);
            end
          end
          StAssert: begin
            if (shreg[0]) begin
              o_ring_low <= 1'b1;
            end else begin
              o_tip_low <= 1'b1;
            end
            timer <= '0;
            state <= StWaitAck;
          end
          StWaitAck: begin
            if (advance) begin
              o_tip_low  <= 1'b0;
              o_ring_low <= 1'b0;
              timer      <= '0;
              state      <= StWaitRel;
            end else begin
              timer <= timer + c_TIMEOUTWIDTH'(1);
            end
          end
          StWaitRel: begin
            if (advance) begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              timer   <= '0;
              state   <= (bit_cnt == 3'd7) ? StDone : StAssert;
            end else begin
              timer <= timer + c_TIMEOUTWIDTH'(1);
            end
          end
          StDone: begin
            timer <= '0;
`ifdef DBUS_TX_GAP_EN
            gap_cnt <= '0;
            state   <= StGap;
`else
            o_busy  <= 1'b0;
            state   <= StIdle;
`endif
          end
          StRecover: begin
            // Both lines must read idle on two consecutive cycles
            if ((s_tip == LineIdle) && (s_ring == LineIdle)) begin
              rec_high <= 1'b1;
              if (rec_high) begin
                o_busy   <= 1'b0;
                rec_high <= 1'b0;
                state    <= StIdle;
              end
            end else begin
              rec_high <= 1'b0;
            end
          end
`ifdef DBUS_TX_GAP_EN
          StGap: begin
            if (gap_cnt == GapLast) begin
              o_busy <= 1'b0;
              state  <= StIdle;
            end else begin
              gap_cnt <= gap_cnt + GapWidth'(1);
            end
          end
`endif
          default: begin
            o_tip_low  <= 1'b0;
            o_ring_low <= 1'b0;
            o_busy     <= 1'b0;
            state      <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbus_tx.sv
// Bench for dbus_tx: FIFO model upstream, D-bus receiver peer downstream, byte scoreboard.
// Build with DBUS_TX_GAP_EN defined to also cover the inter-byte gap.
module tb_dbus_tx;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_avail;
  logic       o_read;
  logic       i_tip;
  logic       i_ring;
  logic       o_tip_low;
  logic       o_ring_low;
  logic       o_busy;
  logic       o_error;

  logic peer_tip  = 1'b0;
  logic peer_ring = 1'b0;
  logic ext_tip   = 1'b0;
  logic peer_en   = 1'b1;
  int   noack_bit = 99;

  assign i_tip  = !(o_tip_low | peer_tip | ext_tip);
  assign i_ring = !(o_ring_low | peer_ring);

  always #5 i_clock = ~i_clock;

  dbus_tx #(
    .c_TIMEOUT      (100),
    .c_TIMEOUTWIDTH (22)
`ifdef DBUS_TX_GAP_EN
    ,
    .c_GAP          (16)
`endif
  ) u_dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .i_avail    (i_avail),
    .o_read     (o_read),
    .i_tip      (i_tip),
    .i_ring     (i_ring),
    .o_tip_low  (o_tip_low),
    .o_ring_low (o_ring_low),
    .o_busy     (o_busy),
    .o_error    (o_error)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q[$];
  int rx_cnt = 0;
  int rx_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: event counters sampled on the falling edge
  int cyc = 0;
  int read_cnt = 0, err_cnt = 0, both_cnt = 0, pull_cnt = 0, pull_avail_cnt = 0;
  int last_rel_cyc = 0, last_gap = 0, ring_run = 0, last_ring_len = 0;
  logic err_lines = 1'b0, err_busy = 1'b0, prev_tip = 1'b0, prev_ring = 1'b0;

  always @(negedge i_clock) begin
    cyc++;
    if (o_read) begin
      read_cnt++;
      last_gap = cyc - last_rel_cyc;
    end
    if (o_error) begin
      err_cnt++;
      err_lines = o_tip_low | o_ring_low;
      err_busy  = o_busy;
    end
    if (o_tip_low && o_ring_low) both_cnt++;
    if ((o_tip_low || o_ring_low) && i_avail) pull_avail_cnt++;
    if ((o_tip_low && !prev_tip) || (o_ring_low && !prev_ring)) pull_cnt++;
    if ((!o_tip_low && prev_tip) || (!o_ring_low && prev_ring)) last_rel_cyc = cyc;
    if (o_ring_low) ring_run++;
    else if (prev_ring) begin
      last_ring_len = ring_run;
      ring_run = 0;
    end
    prev_tip  = o_tip_low;
    prev_ring = o_ring_low;
  end

  // Peer receiver: acks 5 cycles after a pull, releases 3 cycles after the DUT lets go
  initial begin
    int n;
    int bit_idx;
    logic b;
    logic [7:0] rx;
    bit_idx = 0;
    rx = '0;
    forever begin
      @(negedge i_clock);
      if (peer_en && (o_tip_low || o_ring_low)) begin
        b = o_ring_low;
        if (bit_idx == noack_bit) begin
          n = 0;
          while ((o_tip_low || o_ring_low) && n < 1000) begin
            @(negedge i_clock);
            n++;
          end
          bit_idx = 0;
          rx = '0;
        end else begin
          repeat (5) @(negedge i_clock);
          if (b) peer_tip = 1'b1;
          else peer_ring = 1'b1;
          n = 0;
          while ((b ? o_ring_low : o_tip_low) && n < 1000) begin
            @(negedge i_clock);
            n++;
          end
          if (n >= 1000) check("peer_release_wait", 0, 1);
          repeat (3) @(negedge i_clock);
          peer_tip  = 1'b0;
          peer_ring = 1'b0;
          rx = {b, rx[7:1]};
          bit_idx++;
          if (bit_idx == 8) begin
            if (sb_q.size() == 0) check("sb_unexpected_byte", {24'd0, rx}, 32'hFFFF_FFFF);
            else check("rx_byte", {24'd0, rx}, {24'd0, sb_q.pop_front()});
            rx_cnt++;
            bit_idx = 0;
            rx = '0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic offer(input logic [7:0] b);
    i_data  = b;
    i_avail = 1'b1;
  endtask

  // Wait for the read pulse, keep avail high for `hold` cycles, then drop it
  task automatic take(input int hold);
    int n = 0;
    while (!o_read && n < 2000) begin
      @(negedge i_clock);
      n++;
    end
    if (n >= 2000) check("read_wait", 0, 1);
    tick(hold);
    i_avail = 1'b0;
    tick(1);
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    sb_q.push_back(b);
    rx_exp++;
    offer(b);
    take(hold);
  endtask

  task automatic wait_done();
    int n = 0;
    while (rx_cnt < rx_exp && n < 4000) begin
      @(negedge i_clock);
      n++;
    end
    if (n >= 4000) check("rx_wait", rx_cnt, rx_exp);
    n = 0;
    while (o_busy && n < 1000) begin
      @(negedge i_clock);
      n++;
    end
    if (n >= 1000) check("idle_wait", o_busy, 0);
  endtask

  initial begin
    int r0, e0, p0, n;
    i_reset = 1'b1;
    i_data  = '0;
    i_avail = 1'b0;
    tick(3);
    i_reset = 1'b0;
    tick(1);
    check("rst_read", o_read, 0);
    check("rst_tip_low", o_tip_low, 0);
    check("rst_ring_low", o_ring_low, 0);
    check("rst_busy", o_busy, 0);
    check("rst_error", o_error, 0);

    // 0xA5 with responsive peer
    r0 = read_cnt; e0 = err_cnt; p0 = pull_cnt;
    send(8'hA5, 2);
    wait_done();
    check("a5_reads", read_cnt - r0, 1);
    check("a5_errors", err_cnt - e0, 0);
    check("a5_pulls", pull_cnt - p0, 8);

    // avail held 3 cycles after the read pulse
    r0 = read_cnt; p0 = pull_avail_cnt;
    send(8'h5A, 3);
    wait_done();
    check("hold3_reads", read_cnt - r0, 1);
    check("hold3_pull_before_drop", pull_avail_cnt - p0, 0);

    // No ack for bit 3 of 0xFF
    noack_bit = 3;
    e0 = err_cnt;
    offer(8'hFF);
    take(2);
    n = 0;
    while (err_cnt == e0 && n < 2000) begin
      @(negedge i_clock);
      n++;
    end
    if (n >= 2000) check("error_wait", 0, 1);
    check("to_ring_pull_len", last_ring_len, 100);
    check("to_lines_at_error", err_lines, 0);
    check("to_busy_at_error", err_busy, 1);
    tick(3);
    check("to_error_pulse", err_cnt - e0, 1);
    noack_bit = 99;
    wait_done();
    send(8'h01, 2);
    wait_done();

    // Tip held low by a peer: bus busy, nothing starts
    ext_tip = 1'b1;
    tick(4);
    r0 = read_cnt; p0 = pull_cnt;
    sb_q.push_back(8'h33);
    rx_exp++;
    offer(8'h33);
    tick(20);
    check("stuck_reads", read_cnt - r0, 0);
    check("stuck_pulls", pull_cnt - p0, 0);
    ext_tip = 1'b0;
    take(2);
    wait_done();
    check("stuck_reads_after", read_cnt - r0, 1);

    // Reset while waiting for ack on 0x3C
    peer_en = 1'b0;
    offer(8'h3C);
    take(2);
    n = 0;
    while (!o_tip_low && n < 200) begin
      @(negedge i_clock);
      n++;
    end
    if (n >= 200) check("pull_wait", 0, 1);
    tick(3);
    i_reset = 1'b1;
    tick(1);
    check("mid_rst_tip_low", o_tip_low, 0);
    check("mid_rst_ring_low", o_ring_low, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_read", o_read, 0);
    check("mid_rst_error", o_error, 0);
    i_reset = 1'b0;
    peer_en = 1'b1;
    tick(2);
    send(8'hC3, 2);
    wait_done();

`ifdef DBUS_TX_GAP_EN
    send(8'h00, 2);
    send(8'h80, 2);
    check("gap_min_16", (last_gap >= 16) ? 1 : 0, 1);
    wait_done();
`endif

    check("never_both_low", both_cnt, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
